// File: rtl/fetch_if_id_stage.sv
// Instruction-fetch stage and IF/ID pipeline register with req/ready instruction memory port.
// Optional STALL_COUNT_EN adds a free-running count of IF/ID stall cycles on stall_cycles.
//
// state    | meaning
// ST_BOOT  | first cycle after reset, no request issued
// ST_FETCH | request at pc outstanding, loads IF/ID on ready
// ST_HOLD  | fetched word parked in hold buffer while IF/ID is stalled
// ST_DROP  | redirected while a request was in flight; finish it and discard data
module fetch_if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_write,
  input  logic        IF_ID_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr_IF_ID,
  output logic [31:0] pc_plus4_IF_ID,
  output logic        valid_IF_ID
`ifdef STALL_COUNT_EN
  ,output logic [31:0] stall_cycles
`endif
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;

  assign pc_plus4  = pc_q + 32'd4;
  assign imem_req  = (state_q == ST_FETCH) || (state_q == ST_DROP);
  // DROP keeps presenting the abandoned address so the memory sees a stable request
  assign imem_addr = (state_q == ST_DROP) ? drop_addr_q : pc_q;

  assign instr_IF_ID    = instr_q;
  assign pc_plus4_IF_ID = pc4_q;
  assign valid_IF_ID    = valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    hold_instr_d = hold_instr_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;

    if (branch_taken) begin
      pc_d         = branch_target & 32'hFFFF_FFFC;
      instr_d      = NOP_INSTR;
      pc4_d        = '0;
      valid_d      = 1'b0;
      hold_instr_d = '0;
      if (state_q == ST_FETCH && !imem_ready) begin
        state_d     = ST_DROP;
        drop_addr_d = pc_q;
      end else if (state_q != ST_DROP) begin
        state_d = ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_FETCH;
        ST_FETCH: begin
          if (imem_ready) begin
            if (IF_ID_write) begin
              instr_d = imem_rdata;
              pc4_d   = pc_plus4;
              valid_d = 1'b1;
              if (PC_write) pc_d = pc_plus4;
            end else begin
              hold_instr_d = imem_rdata;
              state_d      = ST_HOLD;
            end
          end else if (IF_ID_write) begin
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            valid_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (IF_ID_write) begin
            instr_d = hold_instr_q;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
            state_d = ST_FETCH;
          end
        end
        default: begin
          if (IF_ID_write) begin
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            valid_d = 1'b0;
          end
          if (imem_ready) state_d = ST_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      drop_addr_q  <= '0;
      hold_instr_q <= '0;
      instr_q      <= NOP_INSTR;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      hold_instr_q <= hold_instr_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end

`ifdef STALL_COUNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (!IF_ID_write) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule
